// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ORIEX   = 4'd10,
    S_IMMWB   = 4'd11,
    S_JUMP    = 4'd12,
    S_ILLEGAL = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // fetchgate marks the fetch state, where irwrite/pcen follow mem_ready;
  // branch lets the zero flag drive pcen; aluen marks states that use the ALU.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       fetchgate;
    logic       branch;
    logic       jump;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       zeroext;
    logic       aluen;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

  function automatic logic funct_legal(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req = 1'b1; c.fetchgate = 1'b1; c.alusrcb = SRCB_FOUR;
        c.pcsrc = PC_ALU; c.aluen = 1'b1; c.aluop = ALUOP_ADD;
      end
      S_DECODE: begin
        c.alusrcb = SRCB_IMMSH; c.aluen = 1'b1; c.aluop = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; c.aluen = 1'b1; c.aluop = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1; c.iord = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1; c.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req = 1'b1; c.iord = 1'b1; c.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        c.alusrca = 1'b1; c.alusrcb = SRCB_B; c.aluen = 1'b1; c.aluop = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.regwrite = 1'b1; c.regdst = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = 1'b1; c.alusrcb = SRCB_B; c.aluen = 1'b1; c.aluop = ALUOP_SUB;
        c.pcsrc = PC_ALUOUT; c.branch = 1'b1;
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; c.aluen = 1'b1; c.aluop = ALUOP_ADD;
      end
      S_ORIEX: begin
        c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; c.zeroext = 1'b1;
        c.aluen = 1'b1; c.aluop = ALUOP_OR;
      end
      S_IMMWB: begin
        c.regwrite = 1'b1;
      end
      S_JUMP: begin
        c.pcsrc = PC_JUMP; c.jump = 1'b1;
      end
      S_ILLEGAL: begin
        c.illegal = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps aluop and the R-type funct field to an ALU function code.
module aludec
  import mips_mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Fixed operations for address/branch/ORI, funct lookup for R-type
  always_comb begin
    alucontrol = ALU_AND;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_OR:  alucontrol = ALU_OR;
      default: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing the shared memory port,
// ALU and PC, with illegal-opcode trap and retired/cycle counters.
module mips_multicycle_ctrl
  import mips_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             pcen,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic             zeroext,
  output logic [2:0]       alucontrol,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] cycles
);

  state_t     state;
  state_t     state_nxt;
  ctrl_t      ctrl;
  logic       retire;
  logic       branch_take;
  logic [2:0] alu_dec;

  // Next-state selection; memory states hold until mem_ready, ILLEGAL is terminal
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:   state_nxt = S_MEMADR;
          OP_RTYPE:       state_nxt = funct_legal(funct) ? S_EXECUTE : S_ILLEGAL;
          OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
          OP_ADDI:        state_nxt = S_ADDIEX;
          OP_ORI:         state_nxt = S_ORIEX;
          OP_J:           state_nxt = S_JUMP;
          default:        state_nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  state_nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_nxt = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_nxt = S_FETCH;
      S_EXECUTE: state_nxt = S_ALUWB;
      S_ADDIEX,
      S_ORIEX:   state_nxt = S_IMMWB;
      S_MEMWB,
      S_ALUWB,
      S_IMMWB,
      S_BRANCH,
      S_JUMP:    state_nxt = S_FETCH;
      S_ILLEGAL: state_nxt = S_ILLEGAL;
      default:   state_nxt = S_FETCH;
    endcase
  end

  // An instruction retires in its last cycle; a store only once memory accepts it
  always_comb begin
    retire = 1'b0;
    case (state)
      S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEMWR:                                     retire = mem_ready;
      default:                                     retire = 1'b0;
    endcase
  end

  // State register and performance counters; the trap state freezes both counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      instret <= '0;
      cycles  <= '0;
    end else begin
      state <= state_nxt;
      if (retire) instret <= instret + CNT_W'(1);
      if (state != S_ILLEGAL) cycles <= cycles + CNT_W'(1);
    end
  end

  // Reset masks the decode so a held-in-reset FETCH state cannot request memory
  assign ctrl = reset ? state_ctrl(state) : '0;

  assign branch_take = zero ^ (op == OP_BNE);

  assign mem_req  = ctrl.mem_req;
  assign iord     = ctrl.iord;
  assign memwrite = ctrl.memwrite;
  assign irwrite  = ctrl.fetchgate & mem_ready;
  assign pcen     = (ctrl.fetchgate & mem_ready) | (ctrl.branch & branch_take) | ctrl.jump;
  assign regwrite = ctrl.regwrite;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign zeroext  = ctrl.zeroext;
  assign illegal  = ctrl.illegal;

  aludec u_aludec (
    .aluop      (ctrl.aluop),
    .funct      (funct),
    .alucontrol (alu_dec)
  );

  assign alucontrol = ctrl.aluen ? alu_dec : 3'b000;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: per-cycle scoreboard of expected outputs
// and counters built from an instruction table, plus reset corner sequences.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_BNE   = 6'b000101;
  localparam logic [5:0] T_ADDI  = 6'b001000;
  localparam logic [5:0] T_ORI   = 6'b001101;
  localparam logic [5:0] T_J     = 6'b000010;

  localparam int ST_F = 0, ST_D = 1, ST_MA = 2, ST_MR = 3, ST_MWB = 4, ST_MW = 5,
                 ST_EX = 6, ST_AWB = 7, ST_BR = 8, ST_AE = 9, ST_OE = 10,
                 ST_IWB = 11, ST_J = 12, ST_IL = 13;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  op = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg;
  logic        alusrca, zeroext, illegal;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic [31:0] instret, cycles;
  logic [17:0] act_word;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cycles = '0;
  logic [31:0] exp_instret = '0;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         fwait;
    int         mwait;
  } vec_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mrdy;
    int         st;
  } cyc_t;

  cyc_t sb[$];
  vec_t vecs[22];

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .pcen       (pcen),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .zeroext    (zeroext),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .instret    (instret),
    .cycles     (cycles)
  );

  // Free-running clock
  always #5 clk = ~clk;

  assign act_word = {mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
                     alusrca, alusrcb, pcsrc, zeroext, alucontrol, illegal};

  // Expected control word for one cycle in a given state
  function automatic logic [17:0] exp_outs(int st, logic z, logic bne, logic rdy,
                                           logic [5:0] fn);
    logic       mreq, io, mw, irw, pce, rw, rd, m2r, sa, ze, ill;
    logic [1:0] sbv, ps;
    logic [2:0] ac;
    mreq = 0; io = 0; mw = 0; irw = 0; pce = 0; rw = 0; rd = 0; m2r = 0;
    sa = 0; ze = 0; ill = 0; sbv = 2'b00; ps = 2'b00; ac = 3'b000;
    case (st)
      ST_F:   begin mreq = 1; sbv = 2'b01; ac = 3'b010; irw = rdy; pce = rdy; end
      ST_D:   begin sbv = 2'b11; ac = 3'b010; end
      ST_MA:  begin sa = 1; sbv = 2'b10; ac = 3'b010; end
      ST_MR:  begin mreq = 1; io = 1; end
      ST_MWB: begin rw = 1; m2r = 1; end
      ST_MW:  begin mreq = 1; io = 1; mw = 1; end
      ST_EX: begin
        sa = 1;
        case (fn)
          6'b100000: ac = 3'b010;
          6'b100010: ac = 3'b110;
          6'b100100: ac = 3'b000;
          6'b100101: ac = 3'b001;
          6'b101010: ac = 3'b111;
          default:   ac = 3'b000;
        endcase
      end
      ST_AWB: begin rw = 1; rd = 1; end
      ST_BR:  begin sa = 1; ac = 3'b110; ps = 2'b01; pce = z ^ bne; end
      ST_AE:  begin sa = 1; sbv = 2'b10; ac = 3'b010; end
      ST_OE:  begin sa = 1; sbv = 2'b10; ze = 1; ac = 3'b001; end
      ST_IWB: begin rw = 1; end
      ST_J:   begin ps = 2'b10; pce = 1; end
      ST_IL:  begin ill = 1; end
      default: ;
    endcase
    return {mreq, io, mw, irw, pce, rw, rd, m2r, sa, sbv, ps, ze, ac, ill};
  endfunction

  function automatic logic funct_ok(logic [5:0] fn);
    return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
           fn == 6'b100101 || fn == 6'b101010;
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_cyc(vec_t v, int st, logic rdy);
    cyc_t c;
    c.op = v.op; c.funct = v.funct; c.zero = v.zero; c.mrdy = rdy; c.st = st;
    sb.push_back(c);
  endtask

  task automatic push_mem(vec_t v, int st, int nwait);
    for (int i = 0; i < nwait; i++) push_cyc(v, st, 1'b0);
    push_cyc(v, st, 1'b1);
  endtask

  // Expand one instruction into its expected per-cycle state sequence
  task automatic push_instr(vec_t v);
    push_mem(v, ST_F, v.fwait);
    push_cyc(v, ST_D, 1'($urandom_range(0, 1)));
    case (v.op)
      T_LW: begin
        push_cyc(v, ST_MA, 1'($urandom_range(0, 1)));
        push_mem(v, ST_MR, v.mwait);
        push_cyc(v, ST_MWB, 1'($urandom_range(0, 1)));
      end
      T_SW: begin
        push_cyc(v, ST_MA, 1'($urandom_range(0, 1)));
        push_mem(v, ST_MW, v.mwait);
      end
      T_RTYPE: begin
        if (funct_ok(v.funct)) begin
          push_cyc(v, ST_EX, 1'($urandom_range(0, 1)));
          push_cyc(v, ST_AWB, 1'($urandom_range(0, 1)));
        end else begin
          for (int i = 0; i < 12; i++) push_cyc(v, ST_IL, 1'($urandom_range(0, 1)));
        end
      end
      T_BEQ, T_BNE: push_cyc(v, ST_BR, 1'($urandom_range(0, 1)));
      T_ADDI: begin
        push_cyc(v, ST_AE, 1'($urandom_range(0, 1)));
        push_cyc(v, ST_IWB, 1'($urandom_range(0, 1)));
      end
      T_ORI: begin
        push_cyc(v, ST_OE, 1'($urandom_range(0, 1)));
        push_cyc(v, ST_IWB, 1'($urandom_range(0, 1)));
      end
      T_J: push_cyc(v, ST_J, 1'($urandom_range(0, 1)));
      default: for (int i = 0; i < 12; i++) push_cyc(v, ST_IL, 1'($urandom_range(0, 1)));
    endcase
  endtask

  // Drain the scoreboard: drive each cycle after the edge, compare before the next
  task automatic apply_stimulus();
    cyc_t c;
    int   idx;
    idx = 0;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      op = c.op; funct = c.funct; zero = c.zero; mem_ready = c.mrdy;
      @(negedge clk);
      check_output($sformatf("cyc%0d_st%0d_outs", idx, c.st), 32'(act_word),
                   32'(exp_outs(c.st, c.zero, c.op == T_BNE, c.mrdy, c.funct)));
      check_output($sformatf("cyc%0d_st%0d_cycles", idx, c.st), cycles, exp_cycles);
      check_output($sformatf("cyc%0d_st%0d_instret", idx, c.st), instret, exp_instret);
      if (c.st != ST_IL) exp_cycles = exp_cycles + 1;
      if (c.st == ST_MWB || c.st == ST_AWB || c.st == ST_IWB || c.st == ST_BR ||
          c.st == ST_J || (c.st == ST_MW && c.mrdy))
        exp_instret = exp_instret + 1;
      @(posedge clk);
      #1;
      idx++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    check_output("reset_outs", 32'(act_word), 32'h0);
    check_output("reset_instret", instret, 32'h0);
    check_output("reset_cycles", cycles, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_cycles = '0;
    exp_instret = '0;
  endtask

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    vecs[0]  = '{op: T_LW,    funct: 6'h00,     zero: 1'b0, fwait: 0, mwait: 0};
    vecs[1]  = '{op: T_LW,    funct: 6'h15,     zero: 1'b0, fwait: 3, mwait: 0};
    vecs[2]  = '{op: T_SW,    funct: 6'h00,     zero: 1'b0, fwait: 0, mwait: 0};
    vecs[3]  = '{op: T_RTYPE, funct: 6'b100000, zero: 1'b0, fwait: 0, mwait: 0};
    vecs[4]  = '{op: T_RTYPE, funct: 6'b100010, zero: 1'b1, fwait: 0, mwait: 0};
    vecs[5]  = '{op: T_RTYPE, funct: 6'b100100, zero: 1'b0, fwait: 1, mwait: 0};
    vecs[6]  = '{op: T_RTYPE, funct: 6'b100101, zero: 1'b0, fwait: 0, mwait: 0};
    vecs[7]  = '{op: T_RTYPE, funct: 6'b101010, zero: 1'b0, fwait: 0, mwait: 0};
    vecs[8]  = '{op: T_BEQ,   funct: 6'h00,     zero: 1'b1, fwait: 0, mwait: 0};
    vecs[9]  = '{op: T_BEQ,   funct: 6'h00,     zero: 1'b0, fwait: 0, mwait: 0};
    vecs[10] = '{op: T_BNE,   funct: 6'h00,     zero: 1'b1, fwait: 0, mwait: 0};
    vecs[11] = '{op: T_BNE,   funct: 6'h00,     zero: 1'b0, fwait: 0, mwait: 0};
    vecs[12] = '{op: T_ADDI,  funct: 6'h3f,     zero: 1'b0, fwait: 0, mwait: 0};
    vecs[13] = '{op: T_ORI,   funct: 6'b100010, zero: 1'b0, fwait: 0, mwait: 0};
    vecs[14] = '{op: T_J,     funct: 6'h00,     zero: 1'b0, fwait: 0, mwait: 0};
    vecs[15] = '{op: T_LW,    funct: 6'h00,     zero: 1'b0, fwait: 0, mwait: 2};
    vecs[16] = '{op: T_SW,    funct: 6'h00,     zero: 1'b1, fwait: 2, mwait: 3};
    vecs[17] = '{op: T_ADDI,  funct: 6'h00,     zero: 1'b0, fwait: 0, mwait: 0};
    vecs[18] = '{op: T_BNE,   funct: 6'h00,     zero: 1'b0, fwait: 1, mwait: 0};
    vecs[19] = '{op: T_J,     funct: 6'h00,     zero: 1'b0, fwait: 0, mwait: 0};
    vecs[20] = '{op: 6'b111111, funct: 6'h20,   zero: 1'b0, fwait: 0, mwait: 0};
    vecs[21] = '{op: T_RTYPE, funct: 6'b000000, zero: 1'b0, fwait: 0, mwait: 0};

    $display("[TB] start");
    do_reset();

    // Legal instructions back to back, counters carried across
    for (int i = 0; i < 20; i++) push_instr(vecs[i]);
    apply_stimulus();

    // Illegal opcode traps until reset
    do_reset();
    push_instr(vecs[20]);
    apply_stimulus();

    // Illegal R-type funct traps until reset
    do_reset();
    push_instr(vecs[21]);
    apply_stimulus();

    // Reset in the middle of a stalled store
    do_reset();
    v = vecs[2];
    push_cyc(v, ST_F, 1'b1);
    push_cyc(v, ST_D, 1'b1);
    push_cyc(v, ST_MA, 1'b0);
    push_cyc(v, ST_MW, 1'b0);
    push_cyc(v, ST_MW, 1'b0);
    apply_stimulus();
    op = T_SW; mem_ready = 1'b0;
    #2;
    check_output("midwr_memreq_held", 32'(mem_req), 32'h1);
    check_output("midwr_memwrite_held", 32'(memwrite), 32'h1);
    check_output("midwr_cycles_before", cycles, 32'd5);
    reset = 1'b0;
    #1;
    check_output("midwr_memreq_drop", 32'(mem_req), 32'h0);
    check_output("midwr_memwrite_drop", 32'(memwrite), 32'h0);
    check_output("midwr_instret_clr", instret, 32'h0);
    check_output("midwr_cycles_clr", cycles, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_cycles = '0;
    exp_instret = '0;
    push_instr(vecs[14]);
    push_instr(vecs[0]);
    apply_stimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Control unit for the multicycle MIPS datapath. A shared instruction/data memory port, one ALU and the PC adder are reused across several cycles per instruction, and this block sequences them. It is a Moore FSM with a memory ready/request handshake, branch-condition gating for BEQ/BNE, illegal-opcode trapping, and retired-instruction and cycle counters for performance measurement.

Parameters:
CNT_W, 32, width of the instret and cycles counters (wrap modulo 2^CNT_W)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
op  in  6  instruction register bits [31:26]
funct  in  6  instruction register bits [5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
iord  out  1  0 = address from PC, 1 = address from ALUOut
memwrite  out  1  write strobe, valid only while mem_req=1
irwrite  out  1  load the instruction register
pcen  out  1  PC register enable
regwrite  out  1  register file write enable
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  1 = data register, 0 = ALUOut
alusrca  out  1  0 = PC, 1 = register A
alusrcb  out  2  00 = B, 01 = 4, 10 = imm, 11 = imm<<2
pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
zeroext  out  1  1 = zero-extend the immediate (ORI)
alucontrol  out  3  ALU function code
illegal  out  1  sticky trap flag
instret  out  CNT_W  retired instruction count
cycles  out  CNT_W  cycles since reset, excluding trapped cycles

Behaviour:
- Reset assertion (reset=0) immediately forces: state FETCH, all outputs 0, both counters 0.
- The first cycle after deassertion is FETCH, with mem_req=1.
- Outputs are decoded from state only. Exceptions: irwrite/pcen in FETCH are also gated by mem_ready; pcen in BRANCH is also gated by zero.
- Any output not listed for a state is 0.
- States and outputs:
  - FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, pcsrc=00, aluop=00. irwrite=pcen=mem_ready. mem_ready=1 -> DECODE; otherwise hold FETCH.
  - DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
    - 100011 (LW) or 101011 (SW) -> MEMADR
    - 000000 (R-type) -> EXECUTE if funct is in {100000, 100010, 100100, 100101, 101010}; otherwise ILLEGAL
    - 000100 (BEQ) or 000101 (BNE) -> BRANCH
    - 001000 (ADDI) -> ADDIEX
    - 001101 (ORI) -> ORIEX
    - 000010 (J) -> JUMP
    - any other op -> ILLEGAL
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. LW -> MEMRD; SW -> MEMWR.
  - MEMRD: mem_req=1, iord=1. mem_ready -> MEMWB; otherwise hold.
  - MEMWB: regwrite=1, regdst=0, memtoreg=1 -> FETCH.
  - MEMWR: mem_req=1, iord=1, memwrite=1. mem_ready -> FETCH; otherwise hold with strobes stable.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
  - ALUWB: regwrite=1, regdst=1 -> FETCH.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01. pcen = zero XOR (op==000101) -> FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> IMMWB.
  - ORIEX: alusrca=1, alusrcb=10, zeroext=1, aluop=11 -> IMMWB.
  - IMMWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
  - JUMP: pcsrc=10, pcen=1 -> FETCH.
  - ILLEGAL: illegal=1, every strobe 0, mem_req=0. Only reset exits.
- ALU decode: aluop 00 -> 010 (add), 01 -> 110 (sub), 11 -> 001 (or), 10 -> funct decode (ADD 010, SUB 110, AND 000, OR 001, SLT 111).
- op and funct are sampled from the instruction register. They are valid from DECODE onward and stable until the next FETCH completes.
- Latency with mem_ready tied to 1:
  - LW: 5 cycles
  - SW, R-type, ADDI, ORI: 4 cycles
  - BEQ, BNE, J: 3 cycles
  - Each cycle mem_ready is low in a memory state adds one cycle.
- instret increments by 1 in the final cycle of each instruction: MEMWB, ALUWB, IMMWB, BRANCH, JUMP, and MEMWR qualified by mem_ready.
- cycles increments every cycle except in ILLEGAL. Both counters wrap.
- Reset mid-access (e.g. MEMWR waiting on mem_ready) drops mem_req/memwrite asynchronously. No partial-write guarantee is given to memory.

Decomposition:
- Package mips_mc_pkg holds:
  - state enum (state_t, 4-bit)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J
  - aluop constants
  - alusrcb and pcsrc selector constants
- Reuse the existing aludec unchanged for the aluop/funct -> alucontrol mapping.
- The FSM and counters live in this module.

Test Plan:
- Reset, then LW with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. regwrite=1 and memtoreg=1 only in cycle 5. instret 0->1, cycles=5.
- FETCH with mem_ready=0 for 3 cycles, then 1 -> mem_req=1 for 4 cycles. irwrite=pcen=0 for cycles 1-3 and 1 in cycle 4. DECODE on cycle 5.
- BEQ with zero=1 -> pcen=1, pcsrc=01. BNE with zero=1 -> pcen=0. BNE with zero=0 -> pcen=1. All three take 3 cycles.
- ORI -> ORIEX: alusrcb=10, zeroext=1, alucontrol=001. IMMWB: regwrite=1, regdst=0.
- op=111111, or R-type with funct=000000 -> illegal=1 from the cycle after DECODE. All strobes 0, cycles and instret frozen for 10+ cycles until reset.
- SW with mem_ready=0, reset asserted mid-MEMWR -> mem_req/memwrite=0 the same cycle, counters 0. FETCH resumes after deassertion.
